lynx_tape_player: RTL and testbench

Cassette playback encoder for the Lynx core. It is the transmitting end of the tape path that the ROM LOAD routine reads through port 0x80 bit 0. The block reads a tape image byte by byte from a synchronous buffer RAM and serialises it into a pulse-width-coded `ear` waveform. The waveform is a leader, then a sync byte, then data bytes, and it drives the machine's `ear` input in place of the external line.

---
 rtl/lynx_tape_pkg.sv | 32 +++
 rtl/lynx_tape_bitgen.sv | 82 ++++++++
 rtl/lynx_tape_player.sv | 192 +++++++++++++++++++
 tb/tb_lynx_tape_player.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lynx_tape_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lynx_tape_pkg
//  Purpose  : Shared constants for the Lynx cassette path. Holds the
//             playback state encoding, the default tape timing and framing
//             values, and a helper that picks a bit's half-period. The
//             cassette loader uses the same values.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package lynx_tape_pkg;

  typedef logic [2:0] tape_state_t;

  localparam tape_state_t ST_IDLE   = 3'd0;
  localparam tape_state_t ST_LEADER = 3'd1;
  localparam tape_state_t ST_SYNC   = 3'd2;
  localparam tape_state_t ST_DATA   = 3'd3;
  localparam tape_state_t ST_DONE   = 3'd4;

  localparam int          LEADER_BITS_DEF = 768;
  localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;
  localparam int          ZERO_HALF_DEF   = 1664;
  localparam int          ONE_HALF_DEF    = 832;

  // Half-period, in ticks, used for a bit of value b.
  function automatic int half_ticks(input logic b, input int one_h, input int zero_h);
    return b ? one_h : zero_h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lynx_tape_bitgen.sv
`default_nettype none
// ============================================================================
//  Module   : lynx_tape_bitgen
//  Purpose  : Pulse-width bit cell generator. Each bit is a high half and
//             then a low half of H enabled ticks each. H is ONE_HALF for a
//             '1' and ZERO_HALF for a '0'. A new bit starts on the tick that
//             ends the previous low half, so the bits follow one another with
//             no gap.
//  Ports    : clock, reset (async, active-low)
//             ce, motor  - tick enable and motor; both high = one tick
//             clr        - synchronous abort, forces ear low and idle
//             go         - another bit is wanted when the current one ends
//             bit_val    - value of the bit that starts on this tick
//             ear        - encoded output (equal to the phase flag)
//             bit_done   - one-clock flag on the tick that ends a low half
//             active     - a bit cell is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module lynx_tape_bitgen
  import lynx_tape_pkg::*;
#(
  parameter int ZERO_HALF = ZERO_HALF_DEF,
  parameter int ONE_HALF  = ONE_HALF_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic motor,
  input  logic clr,
  input  logic go,
  input  logic bit_val,
  output logic ear,
  output logic bit_done,
  output logic active
);

  localparam int CW = (ZERO_HALF > 2) ? $clog2(ZERO_HALF) : 1;

  logic [CW-1:0] count;
  logic [CW-1:0] half_m1;
  logic          phase;
  logic          tick;
  logic          half_end;
  logic          rise;

  assign tick     = ce & motor;
  assign half_end = tick & active & (count == half_m1);
  assign bit_done = half_end & ~phase;
  // A new cell starts from idle, or back to back on the tick that ends a cell.
  assign rise     = tick & go & (~active | bit_done);
  assign ear      = phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active  <= 1'b0;
      phase   <= 1'b0;
      count   <= '0;
      half_m1 <= '0;
    end else if (clr) begin
      active  <= 1'b0;
      phase   <= 1'b0;
      count   <= '0;
      half_m1 <= '0;
    end else if (rise) begin
      active  <= 1'b1;
      phase   <= 1'b1;
      count   <= '0;
      half_m1 <= CW'(half_ticks(bit_val, ONE_HALF, ZERO_HALF) - 1);
    end else if (bit_done) begin
      active  <= 1'b0;
      phase   <= 1'b0;
      count   <= '0;
    end else if (half_end) begin
      phase   <= 1'b0;
      count   <= '0;
    end else if (tick && active) begin
      count   <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lynx_tape_player.sv
`default_nettype none
// ============================================================================
//  Module   : lynx_tape_player
//  Purpose  : Cassette playback encoder. Sends a leader of '0' bits, then
//             SYNC_BYTE, then len bytes read from a synchronous buffer RAM,
//             all MSB first, as a pulse-width coded ear signal.
//             LEADER_BITS must be at least 1.
//  Ports    : clock, reset (async, active-low)
//             ce            - timing tick enable
//             start, stop   - level controls (stop has priority)
//             motor         - low freezes playback in place
//             base, len     - first buffer address and byte count
//             rd, rd_addr   - one-clock read strobe and address
//             rd_data       - buffer data, valid the clock after rd
//             ear           - encoded tape signal
//             busy, done    - activity flag and completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module lynx_tape_player
  import lynx_tape_pkg::*;
#(
  parameter int         AW          = 16,
  parameter int         LEADER_BITS = LEADER_BITS_DEF,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         ZERO_HALF   = ZERO_HALF_DEF,
  parameter int         ONE_HALF    = ONE_HALF_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          start,
  input  logic          stop,
  input  logic          motor,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  output logic          rd,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          ear,
  output logic          busy,
  output logic          done
);

  localparam int BCW = $clog2(((LEADER_BITS > 8) ? LEADER_BITS : 8) + 1);

  tape_state_t    state;
  logic [BCW-1:0] cnt;        // bits left in the current segment, incl. the one on air
  logic [7:0]     sr;         // sr[7] is the bit on air in SYNC/DATA
  logic [7:0]     nxt;        // prefetched next data byte
  logic [AW-1:0]  base_r;
  logic [AW-1:0]  left;       // bytes not yet fetched
  logic [AW-1:0]  idx;
  logic           have_next;  // a read was issued for the byte after this one
  logic           pend;       // read result arrives this clock

  logic           go;
  logic           bit_val;
  logic           bit_done;
  logic           bit_active;
  logic           abort;

  assign abort = stop && (state != ST_IDLE);
  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);

  // Bit offered to the generator: the bit that follows the one on air, since
  // the generator starts a new cell on the tick that ends the current one.
  always_comb begin
    go      = 1'b0;
    bit_val = 1'b0;
    case (state)
      ST_LEADER: begin
        go      = 1'b1;
        bit_val = (bit_active && cnt == BCW'(1)) ? SYNC_BYTE[7] : 1'b0;
      end
      ST_SYNC, ST_DATA: begin
        if (cnt == BCW'(1)) begin
          go      = have_next;
          bit_val = nxt[7];
        end else begin
          go      = 1'b1;
          bit_val = sr[6];
        end
      end
      default: begin
        go      = 1'b0;
        bit_val = 1'b0;
      end
    endcase
  end

  lynx_tape_bitgen #(
    .ZERO_HALF (ZERO_HALF),
    .ONE_HALF  (ONE_HALF)
  ) u_bitgen (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .motor    (motor),
    .clr      (abort),
    .go       (go),
    .bit_val  (bit_val),
    .ear      (ear),
    .bit_done (bit_done),
    .active   (bit_active)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sr        <= '0;
      nxt       <= '0;
      base_r    <= '0;
      left      <= '0;
      idx       <= '0;
      have_next <= 1'b0;
      pend      <= 1'b0;
      rd        <= 1'b0;
      rd_addr   <= '0;
    end else begin
      rd   <= 1'b0;
      pend <= rd;
      // The capture does not depend on the tick, so it completes while paused.
      if (pend) begin
        nxt <= rd_data;
      end
      if (abort) begin
        state     <= ST_IDLE;
        pend      <= 1'b0;
        have_next <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !stop) begin
              state     <= ST_LEADER;
              base_r    <= base;
              left      <= len;
              idx       <= '0;
              cnt       <= BCW'(LEADER_BITS);
              have_next <= 1'b0;
            end
          end
          ST_LEADER: begin
            if (bit_done) begin
              if (cnt == BCW'(1)) begin
                state <= ST_SYNC;
                sr    <= SYNC_BYTE;
                cnt   <= BCW'(8);
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
          end
          ST_SYNC, ST_DATA: begin
            if (bit_done) begin
              if (cnt == BCW'(1)) begin
                if (have_next) begin
                  state     <= ST_DATA;
                  sr        <= nxt;
                  cnt       <= BCW'(8);
                  have_next <= 1'b0;
                end else begin
                  state <= ST_DONE;
                end
              end else begin
                sr  <= sr << 1;
                cnt <= cnt - 1'b1;
                // The LSB starts now: fetch the following byte while it plays.
                if (cnt == BCW'(2) && left != '0) begin
                  rd        <= 1'b1;
                  rd_addr   <= base_r + idx;
                  idx       <= idx + 1'b1;
                  left      <= left - 1'b1;
                  have_next <= 1'b1;
                end
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lynx_tape_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lynx_tape_player
//  Purpose  : Self-checking bench for lynx_tape_player with short timing
//             (4 leader bits, zero half 4, one half 2, ce every clock).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lynx_tape_player;

  logic        clock;
  logic        reset;
  logic        ce;
  logic        start;
  logic        stop;
  logic        motor;
  logic [15:0] base_in;
  logic [15:0] len_in;
  logic        rd;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        ear;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:65535];
  logic       wave [$];

  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int          pause_at;
    int          exp_done;
    int          exp_nrd;
    logic [15:0] exp_a0;
    logic [15:0] exp_a1;
    int          exp_rdw0;
  } vec_t;

  vec_t vecs [5];

  lynx_tape_player #(
    .AW          (16),
    .LEADER_BITS (4),
    .SYNC_BYTE   (8'hA5),
    .ZERO_HALF   (4),
    .ONE_HALF    (2)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .start   (start),
    .stop    (stop),
    .motor   (motor),
    .base    (base_in),
    .len     (len_in),
    .rd      (rd),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .ear     (ear),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous buffer RAM: data appears the clock after rd.
  always @(posedge clock) begin
    if (rd) rd_data <= mem[rd_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_bit(input logic b);
    int h;
    h = b ? 2 : 4;
    for (int k = 0; k < h; k++) wave.push_back(1'b1);
    for (int k = 0; k < h; k++) wave.push_back(1'b0);
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int k = 7; k >= 0; k--) push_bit(v[k]);
  endtask

  task automatic build_wave(input int n, input logic [7:0] d0, input logic [7:0] d1);
    wave.delete();
    for (int k = 0; k < 4; k++) push_bit(1'b0);
    push_byte(8'hA5);
    if (n > 0) push_byte(d0);
    if (n > 1) push_byte(d1);
  endtask

  task automatic run_vec(input int i);
    logic [15:0] a0, a1, nb;
    int          w, pauses, nrd, done_at, ear_err, rdw0;
    logic        exp_e;
    a0 = '0; a1 = '0; rdw0 = -1;
    nb = vecs[i].base + 16'd1;
    mem[vecs[i].base] = vecs[i].d0;
    mem[nb]           = vecs[i].d1;
    build_wave(int'(vecs[i].len), vecs[i].d0, vecs[i].d1);
    base_in = vecs[i].base;
    len_in  = vecs[i].len;
    motor   = 1'b1;
    start   = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check($sformatf("v%0d busy_after_start", i), busy, 1);
    check($sformatf("v%0d ear_before_rise", i), ear, 0);
    @(posedge clock); #1;
    check($sformatf("v%0d first_rise", i), ear, 1);
    w = 0; pauses = 0; nrd = 0; done_at = -1; ear_err = 0;
    for (int c = 1; c < 2000; c++) begin
      if (vecs[i].pause_at != 0 && w == vecs[i].pause_at && pauses < 50) begin
        motor = 1'b0;
        pauses++;
      end else begin
        motor = 1'b1;
      end
      @(posedge clock); #1;
      if (motor) w++;
      exp_e = (w < wave.size()) ? wave[w] : 1'b0;
      if (ear !== exp_e) ear_err++;
      if (rd === 1'b1) begin
        if (nrd == 0) begin
          a0   = rd_addr;
          rdw0 = w;
        end else if (nrd == 1) begin
          a1 = rd_addr;
        end
        nrd++;
      end
      if (done === 1'b1) begin
        done_at = c;
        break;
      end
    end
    motor = 1'b1;
    check($sformatf("v%0d ear_wave_errs", i), ear_err, 0);
    check($sformatf("v%0d done_cycle", i), done_at, vecs[i].exp_done);
    check($sformatf("v%0d rd_count", i), nrd, vecs[i].exp_nrd);
    if (vecs[i].exp_nrd >= 1) begin
      check($sformatf("v%0d rd_addr0", i), a0, vecs[i].exp_a0);
      check($sformatf("v%0d rd_tick0", i), rdw0, vecs[i].exp_rdw0);
    end
    if (vecs[i].exp_nrd >= 2) begin
      check($sformatf("v%0d rd_addr1", i), a1, vecs[i].exp_a1);
    end
    @(posedge clock); #1;
    check($sformatf("v%0d done_width", i), done, 0);
    check($sformatf("v%0d busy_end", i), busy, 0);
  endtask

  initial begin
    int ear_err, ndone;

    //           base      len    d0     d1     pause done nrd a0        a1        rdw0
    vecs[0] = '{16'h0100, 16'd2, 8'h3C, 8'hFF, 0,   160, 2, 16'h0100, 16'h0101, 76};
    vecs[1] = '{16'h1234, 16'd0, 8'h00, 8'h00, 0,   80,  0, 16'h0000, 16'h0000, 0};
    vecs[2] = '{16'hFFFF, 16'd2, 8'h81, 8'h7E, 0,   176, 2, 16'hFFFF, 16'h0000, 76};
    vecs[3] = '{16'h0200, 16'd1, 8'h00, 8'h55, 0,   144, 1, 16'h0200, 16'h0000, 76};
    vecs[4] = '{16'h0100, 16'd2, 8'h3C, 8'hFF, 100, 210, 2, 16'h0100, 16'h0101, 76};

    reset = 1'b0; ce = 1'b1; start = 1'b0; stop = 1'b0; motor = 1'b1;
    base_in = '0; len_in = '0;
    #12 reset = 1'b1;
    @(posedge clock); #1;
    check("reset ear", ear, 0);
    check("reset rd", rd, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset rd_addr", rd_addr, 0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Stop during the second data byte (0xFF plays at ticks 128..159).
    mem[16'h0100] = 8'h3C;
    mem[16'h0101] = 8'hFF;
    base_in = 16'h0100; len_in = 16'd2; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (141) @(posedge clock);
    #1;
    check("stop busy_before", busy, 1);
    stop = 1'b1;
    @(posedge clock); #1;
    stop = 1'b0;
    check("stop ear", ear, 0);
    check("stop busy", busy, 0);
    check("stop done", done, 0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    check("stop no_done_after", ndone, 0);
    run_vec(0);

    // Start held high while busy, then asynchronous reset mid-SYNC.
    build_wave(2, 8'h3C, 8'hFF);
    base_in = 16'h0100; len_in = 16'd2; start = 1'b1;
    @(posedge clock); #1;
    ear_err = 0;
    for (int c = 0; c <= 50; c++) begin
      @(posedge clock); #1;
      if (ear !== wave[c]) ear_err++;
    end
    check("held_start wave_errs", ear_err, 0);
    check("held_start busy", busy, 1);
    check("held_start ear_high", ear, 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset ear", ear, 0);
    check("async_reset rd", rd, 0);
    check("async_reset busy", busy, 0);
    check("async_reset done", done, 0);
    check("async_reset rd_addr", rd_addr, 0);
    start = 1'b0;
    #2 reset = 1'b1;
    run_vec(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
